// File: rtl/uart_rx_frame_buffer_if.sv
// Signal bundle between the UART RX front end, the frame buffer and the host.
// The slave modport is the buffer's view; the master modport is the producer/consumer view.
interface uart_rx_frame_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned ERR_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_err;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  full;
  logic                  overflow;
  logic [ERR_WIDTH-1:0]  err_count;
  logic                  clear_flags;

  modport slave (
    input  rx_data, rx_valid, rx_err, out_ready, clear_flags,
    output out_data, out_valid, fifo_count, full, overflow, err_count
  );

  modport master (
    output rx_data, rx_valid, rx_err, out_ready, clear_flags,
    input  out_data, out_valid, fifo_count, full, overflow, err_count
  );
endinterface

// File: rtl/uart_rx_frame_buffer.sv
// Circular show-ahead FIFO capturing good UART frames on the rising edge of rx_valid,
// with a sticky overflow flag and a saturating frame-error counter for host status.
module uart_rx_frame_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_frame_buffer_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic                  r_rx_valid_q;
  logic                  r_rx_err_q;

  logic w_push;
  logic w_err_ev;
  logic w_out_valid;
  logic w_full;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  always_comb begin
    w_push      = bus.rx_valid & ~r_rx_valid_q;
    w_err_ev    = bus.rx_err & ~r_rx_err_q;
    w_out_valid = (r_count != '0);
    w_full      = (r_count == LP_DEPTH);
    w_pop       = w_out_valid & bus.out_ready;
    // A pop in the same cycle frees the slot the full-FIFO write lands in.
    w_wr_en     = w_push & (~w_full | w_pop);
    w_drop      = w_push & w_full & ~w_pop;
  end

  // Edge-detect history resets high so a strobe held across reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid_q <= 1'b1;
      r_rx_err_q   <= 1'b1;
    end else begin
      r_rx_valid_q <= bus.rx_valid;
      r_rx_err_q   <= bus.rx_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags: a same-cycle event takes priority over clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_flags) begin
        r_overflow <= 1'b0;
      end

      if (w_err_ev) begin
        if (bus.clear_flags) begin
          r_err_count <= ERR_WIDTH'(1);
        end else if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
      end else if (bus.clear_flags) begin
        r_err_count <= '0;
      end
    end
  end

  always_comb begin
    bus.out_valid  = w_out_valid;
    bus.out_data   = w_out_valid ? r_mem[r_rd_ptr] : '0;
    bus.fifo_count = r_count;
    bus.full       = w_full;
    bus.overflow   = r_overflow;
    bus.err_count  = r_err_count;
  end

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Directed bench for uart_rx_frame_buffer: a vector table for single-cycle behaviour
// plus hand-written sequences for overflow, error saturation and reset mid-operation.
module tb_uart_rx_frame_buffer;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  uart_rx_frame_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ERR_WIDTH(8)) bus ();

  uart_rx_frame_buffer #(
    .DATA_WIDTH(8),
    .DEPTH(8),
    .ADDR_WIDTH(3),
    .ERR_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       e;
    logic       r;
    logic       c;
    logic       ev;
    logic [7:0] ed;
    logic [3:0] ecnt;
    logic       efull;
    logic       eovf;
    logic [7:0] eerr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic e,
                              input logic r, input logic c, input logic ev,
                              input logic [7:0] ed, input logic [3:0] ecnt,
                              input logic efull, input logic eovf, input logic [7:0] eerr);
    vec_t t;
    t.d = d; t.v = v; t.e = e; t.r = r; t.c = c;
    t.ev = ev; t.ed = ed; t.ecnt = ecnt; t.efull = efull; t.eovf = eovf; t.eerr = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [3:0] ecnt, input logic efull, input logic eovf,
                         input logic [7:0] eerr);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(ev));
    chk({tag, ".out_data"},   32'(bus.out_data),   32'(ed));
    chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(ecnt));
    chk({tag, ".full"},       32'(bus.full),       32'(efull));
    chk({tag, ".overflow"},   32'(bus.overflow),   32'(eovf));
    chk({tag, ".err_count"},  32'(bus.err_count),  32'(eerr));
  endtask

  // Drive inputs on the falling edge, then sample 1ns after the rising edge.
  task automatic cyc(input logic [7:0] d, input logic v, input logic e,
                     input logic r, input logic c);
    @(negedge clk);
    bus.rx_data = d; bus.rx_valid = v; bus.rx_err = e;
    bus.out_ready = r; bus.clear_flags = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_err = 1'b0;
    bus.out_ready = 1'b0; bus.clear_flags = 1'b0;

    //            d      v  e  r  c  ev  ed     cnt full ovf err
    vecs[0]  = mk(8'h00, 0, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 8'd0);
    vecs[1]  = mk(8'hA5, 1, 0, 0, 0, 1, 8'hA5, 4'd1, 0, 0, 8'd0);
    vecs[2]  = mk(8'h00, 0, 0, 0, 0, 1, 8'hA5, 4'd1, 0, 0, 8'd0);
    vecs[3]  = mk(8'h3C, 1, 0, 0, 0, 1, 8'hA5, 4'd2, 0, 0, 8'd0);
    vecs[4]  = mk(8'h3C, 1, 0, 0, 0, 1, 8'hA5, 4'd2, 0, 0, 8'd0);
    vecs[5]  = mk(8'h3C, 1, 0, 0, 0, 1, 8'hA5, 4'd2, 0, 0, 8'd0);
    vecs[6]  = mk(8'h3C, 1, 0, 0, 0, 1, 8'hA5, 4'd2, 0, 0, 8'd0);
    vecs[7]  = mk(8'h3C, 1, 0, 0, 0, 1, 8'hA5, 4'd2, 0, 0, 8'd0);
    vecs[8]  = mk(8'h00, 0, 0, 1, 0, 1, 8'h3C, 4'd1, 0, 0, 8'd0);
    vecs[9]  = mk(8'h00, 0, 0, 1, 0, 0, 8'h00, 4'd0, 0, 0, 8'd0);
    vecs[10] = mk(8'h00, 0, 0, 1, 0, 0, 8'h00, 4'd0, 0, 0, 8'd0);
    vecs[11] = mk(8'h00, 0, 1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 8'd1);
    vecs[12] = mk(8'h00, 0, 1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 8'd1);
    vecs[13] = mk(8'h77, 1, 0, 1, 0, 1, 8'h77, 4'd1, 0, 0, 8'd1);
    vecs[14] = mk(8'h00, 0, 1, 1, 0, 0, 8'h00, 4'd0, 0, 0, 8'd2);
    vecs[15] = mk(8'h00, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0, 8'd0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].d, vecs[i].v, vecs[i].e, vecs[i].r, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ecnt,
              vecs[i].efull, vecs[i].eovf, vecs[i].eerr);
    end

    // Nine pushes into an 8-deep FIFO: the ninth is dropped.
    for (int i = 1; i <= 9; i++) begin
      cyc(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_all("fill9", 1'b1, 8'h01, 4'd8, 1'b1, 1'b1, 8'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("clr_ovf", 1'b1, 8'h01, 4'd8, 1'b1, 1'b0, 8'd0);
    cyc(8'h0A, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("drop_vs_clr", 1'b1, 8'h01, 4'd8, 1'b1, 1'b1, 8'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Push and pop together while full.
    chk("pop_head1", 32'(bus.out_data), 32'h01);
    cyc(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("full_pushpop", 1'b1, 8'h02, 4'd8, 1'b1, 1'b1, 8'd0);
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("pop_head%0d", k), 32'(bus.out_data), 32'(k));
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("pop_cnt%0d", k), 32'(bus.fifo_count), 32'(9 - k));
    end
    chk("pop_head55", 32'(bus.out_data), 32'h55);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("drained", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 8'd0);

    // Error counter saturation, then clear racing a new error edge.
    for (int i = 0; i < 260; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("err_sat", 32'(bus.err_count), 32'd255);
    chk("err_fifo_untouched", 32'(bus.fifo_count), 32'd0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("err_clr_race", 32'(bus.err_count), 32'd1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_clr", 32'(bus.err_count), 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with queued data and rx_valid held high across release.
    cyc(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_cnt", 32'(bus.fifo_count), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    bus.rx_data = 8'h44; bus.rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("in_reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset1", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0);
    cyc(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("post_reset2", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("recover", 1'b1, 8'h99, 4'd1, 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
